// File: rtl/mem_arbiter.sv
// Arbitrates N_CH requesters onto a byte-wide memory port; byte/half/word moved one byte per cycle.
// Latency: done pulses n+1 cycles (write) or n+2 cycles (read) after the request is sampled, n = 1/2/4.
// Backpressure: rdy_in low freezes all state; IO-region writes retry in place while io_buffer_full is high.
module mem_arbiter #(
   parameter int N_CH    = 2,
   parameter int RR_MODE = 0
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic [N_CH-1:0]      req_valid,
   input  logic [N_CH-1:0]      req_wr,
   input  logic [32*N_CH-1:0]   req_addr,
   input  logic [2*N_CH-1:0]    req_size,
   input  logic [32*N_CH-1:0]   req_wdata,
   input  logic [N_CH-1:0]      flush,
   output logic [N_CH-1:0]      done,
   output logic [31:0]          rdata,
   output logic                 busy,
   output logic [2:0]           grant_id,
   input  logic [7:0]           mem_din,
   output logic [7:0]           mem_dout,
   output logic [31:0]          mem_a,
   output logic                 mem_wr,
   input  logic                 io_buffer_full
);

   typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, WAIT = 2'd2} state_t;

   state_t          state, state_nxt;
   logic [2:0]      ch_q, last_grant;
   logic [31:0]     addr_q, wdata_q, rd_acc;
   logic [1:0]      size_q, idx_q, last_idx;
   logic            wr_q;

   logic [N_CH-1:0] eligible, ch_mask, elig_sh;
   logic            win_found;
   logic [2:0]      win_ch;
   int              cand;
   logic [31:0]     win_addr, win_wdata;
   logic [1:0]      win_size;
   logic            win_wr;
   logic [31:0]     cur_addr;
   logic            stall, abort, last_byte;

   function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
      case (k)
         2'd0:    byte_of = w[7:0];
         2'd1:    byte_of = w[15:8];
         2'd2:    byte_of = w[23:16];
         default: byte_of = w[31:24];
      endcase
   endfunction

   function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] k,
                                            input logic [7:0] b);
      put_byte = w;
      case (k)
         2'd0:    put_byte[7:0]   = b;
         2'd1:    put_byte[15:8]  = b;
         2'd2:    put_byte[23:16] = b;
         default: put_byte[31:24] = b;
      endcase
   endfunction

   // A channel showing done this cycle sits out so it cannot be re-granted back to back.
   assign eligible  = req_valid & ~flush & ~done;
   assign ch_mask   = N_CH'(1) << ch_q;
   assign last_idx  = (size_q == 2'd0) ? 2'd0 : (size_q == 2'd1) ? 2'd1 : 2'd3;
   assign last_byte = (idx_q == last_idx);
   assign cur_addr  = addr_q + {30'd0, idx_q};
   assign stall     = (state == XFER) && wr_q && (cur_addr[17:16] == 2'b11) && io_buffer_full;
   assign abort     = ((state == XFER) || (state == WAIT)) && !wr_q && (|(flush & ch_mask));

   // Winner search: upward from channel 0, or upward from the channel after the last grant.
   always_comb begin
      win_found = 1'b0;
      win_ch    = 3'd0;
      cand      = 0;
      elig_sh   = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (RR_MODE != 0) cand = (int'(last_grant) + 1 + i) % N_CH;
         else              cand = i;
         elig_sh = eligible >> cand;
         if (!win_found && elig_sh[0]) begin
            win_found = 1'b1;
            win_ch    = 3'(cand);
         end
      end
   end

   // Select the winning channel's request fields.
   always_comb begin
      win_addr  = '0;
      win_wdata = '0;
      win_size  = '0;
      win_wr    = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (win_ch == 3'(i)) begin
            win_addr  = req_addr[32*i +: 32];
            win_wdata = req_wdata[32*i +: 32];
            win_size  = req_size[2*i +: 2];
            win_wr    = req_wr[i];
         end
      end
   end

   // Next-state logic: reads take one extra WAIT cycle to catch the final memory byte.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (win_found) state_nxt = XFER;
         XFER: begin
            if (abort)                      state_nxt = IDLE;
            else if (!stall && last_byte)   state_nxt = wr_q ? IDLE : WAIT;
         end
         WAIT:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register; rdy_in low holds the machine exactly where it is.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)      state <= IDLE;
      else if (rdy_in) state <= state_nxt;
   end

   // Request latch, byte index, read assembly and completion pulse.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         ch_q       <= 3'd0;
         last_grant <= 3'(N_CH - 1);
         addr_q     <= '0;
         wdata_q    <= '0;
         size_q     <= '0;
         wr_q       <= 1'b0;
         idx_q      <= '0;
         rd_acc     <= '0;
         rdata      <= '0;
         done       <= '0;
      end else if (rdy_in) begin
         done <= '0;
         case (state)
            IDLE: begin
               if (win_found) begin
                  ch_q       <= win_ch;
                  last_grant <= win_ch;
                  addr_q     <= win_addr;
                  wdata_q    <= win_wdata;
                  size_q     <= win_size;
                  wr_q       <= win_wr;
                  idx_q      <= 2'd0;
                  rd_acc     <= '0;
               end
            end
            XFER: begin
               if (!abort) begin
                  // mem_din now carries the byte addressed in the previous cycle.
                  if (!wr_q && (idx_q != 2'd0)) rd_acc <= put_byte(rd_acc, idx_q - 2'd1, mem_din);
                  if (!stall) begin
                     idx_q <= idx_q + 2'd1;
                     if (last_byte && wr_q) done <= ch_mask;
                  end
               end
            end
            WAIT: begin
               // rdata only changes on a completed read, so a flushed read leaves it intact.
               if (!abort) begin
                  rdata <= put_byte(rd_acc, last_idx, mem_din);
                  done  <= ch_mask;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy     = (state != IDLE);
   assign grant_id = ch_q;
   assign mem_a    = (state == XFER) ? cur_addr : 32'd0;
   assign mem_wr   = (state == XFER) && wr_q && !stall && rdy_in;
   assign mem_dout = ((state == XFER) && wr_q) ? byte_of(wdata_q, idx_q) : 8'h00;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: fixed-priority and round-robin instances.
// Stimulus pushes expected write/done events; monitors pop and compare on each DUT output event.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_mem_arbiter;

   typedef struct {
      int          kind;   // 0 = memory write, 1 = done pulse
      logic [31:0] a;      // write address, or the done vector
      logic [31:0] d;      // write byte, or rdata
      bit          chk_d;
      int          cyc;
   } ev_t;

   logic clk = 1'b0;
   logic rst;
   logic rdy;
   logic io_full;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   base;

   ev_t  q0[$];
   ev_t  q1[$];

   logic [7:0]  mem [256];

   // Fixed-priority instance signals
   logic [1:0]  rv0, rw0, fl0, done0;
   logic [63:0] ra0, rwd0;
   logic [3:0]  rs0;
   logic [31:0] rdata0, mem_a0;
   logic        busy0, mem_wr0;
   logic [2:0]  gid0;
   logic [7:0]  mem_din0, mem_dout0;

   // Round-robin instance signals
   logic [1:0]  rv1, rw1, fl1, done1;
   logic [63:0] ra1, rwd1;
   logic [3:0]  rs1;
   logic [31:0] rdata1, mem_a1;
   logic        busy1, mem_wr1;
   logic [2:0]  gid1;
   logic [7:0]  mem_dout1;

   mem_arbiter #(.N_CH(2), .RR_MODE(0)) dut0 (
      .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
      .req_valid(rv0), .req_wr(rw0), .req_addr(ra0), .req_size(rs0), .req_wdata(rwd0),
      .flush(fl0), .done(done0), .rdata(rdata0), .busy(busy0), .grant_id(gid0),
      .mem_din(mem_din0), .mem_dout(mem_dout0), .mem_a(mem_a0), .mem_wr(mem_wr0),
      .io_buffer_full(io_full)
   );

   mem_arbiter #(.N_CH(2), .RR_MODE(1)) dut1 (
      .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
      .req_valid(rv1), .req_wr(rw1), .req_addr(ra1), .req_size(rs1), .req_wdata(rwd1),
      .flush(fl1), .done(done1), .rdata(rdata1), .busy(busy1), .grant_id(gid1),
      .mem_din(8'h00), .mem_dout(mem_dout1), .mem_a(mem_a1), .mem_wr(mem_wr1),
      .io_buffer_full(io_full)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: read byte appears the cycle after its address.
   always @(posedge clk) mem_din0 <= mem[mem_a0[7:0]];

   function automatic ev_t mk(input int k, input logic [31:0] a, input logic [31:0] d,
                              input bit c, input int cy);
      ev_t e;
      e.kind = k; e.a = a; e.d = d; e.chk_d = c; e.cyc = cy;
      return e;
   endfunction

   task automatic observe(input int dut, input ev_t act);
      ev_t exp;
      bit  have;
      have = 1'b0;
      exp  = mk(0, 0, 0, 0, 0);
      if (dut == 0 && q0.size() > 0) begin exp = q0.pop_front(); have = 1'b1; end
      if (dut == 1 && q1.size() > 0) begin exp = q1.pop_front(); have = 1'b1; end
      n_cmp++;
      if (!have) begin
         n_bad++;
         $display("FAIL unexpected_evt dut%0d: got kind=%0d a=%h d=%h cyc=%0d, expected no event",
                  dut, act.kind, act.a, act.d, act.cyc);
      end else if (exp.kind != act.kind || exp.a !== act.a || exp.cyc != act.cyc ||
                   (exp.chk_d && exp.d !== act.d)) begin
         n_bad++;
         $display("FAIL evt dut%0d: got kind=%0d a=%h d=%h cyc=%0d, expected kind=%0d a=%h d=%h cyc=%0d",
                  dut, act.kind, act.a, act.d, act.cyc, exp.kind, exp.a, exp.d, exp.cyc);
      end
   endtask

   // Monitors: every write strobe and done pulse must match the next expected event.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (mem_wr0) observe(0, mk(0, mem_a0, {24'h0, mem_dout0}, 1'b1, cyc));
         if (|done0)  observe(0, mk(1, {30'h0, done0}, rdata0, 1'b1, cyc));
         if (mem_wr1) observe(1, mk(0, mem_a1, {24'h0, mem_dout1}, 1'b1, cyc));
         if (|done1)  observe(1, mk(1, {30'h0, done1}, rdata1, 1'b1, cyc));
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      foreach (mem[i]) mem[i] = 8'h00;
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
      rst = 1'b1; rdy = 1'b1; io_full = 1'b0;
      rv0 = '0; rw0 = '0; fl0 = '0; ra0 = '0; rwd0 = '0; rs0 = '0;
      rv1 = '0; rw1 = '0; fl1 = '0; ra1 = '0; rwd1 = '0; rs1 = '0;
      #2;
      chk("rst_done",   {30'h0, done0}, 32'h0);
      chk("rst_rdata",  rdata0, 32'h0);
      chk("rst_busy",   {31'h0, busy0}, 32'h0);
      chk("rst_grant",  {29'h0, gid0}, 32'h0);
      chk("rst_mem_a",  mem_a0, 32'h0);
      chk("rst_mem_wr", {31'h0, mem_wr0}, 32'h0);
      chk("rst_dout",   {24'h0, mem_dout0}, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      tick(); tick();

      // Word read, channel 0, 0x100
      rw0[0] = 1'b0; ra0[31:0] = 32'h100; rs0[1:0] = 2'd2; rv0[0] = 1'b1; base = cyc;
      q0.push_back(mk(1, 32'h1, 32'h44332211, 1'b1, base + 6));
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("word_rd_mem_a", mem_a0, 32'h100 + 32'(k - 1));
      end
      tick();
      chk("word_rd_busy_wait", {31'h0, busy0}, 32'h1);
      tick();
      rv0[0] = 1'b0;
      tick(); tick();
      chk("word_rd_rdata_hold", rdata0, 32'h44332211);

      // Byte read, channel 1, 0x102: zero-extended
      rw0[1] = 1'b0; ra0[63:32] = 32'h102; rs0[3:2] = 2'd0; rv0[1] = 1'b1; base = cyc;
      q0.push_back(mk(1, 32'h2, 32'h00000033, 1'b1, base + 3));
      tick(); tick(); tick();
      rv0[1] = 1'b0;
      tick(); tick();

      // Half write to IO region, buffer full for cycles 1-3
      rw0[1] = 1'b1; ra0[63:32] = 32'h30000; rs0[3:2] = 2'd1; rwd0[63:32] = 32'hABCD;
      io_full = 1'b1; rv0[1] = 1'b1; base = cyc;
      q0.push_back(mk(0, 32'h30000, 32'hCD, 1'b1, base + 4));
      q0.push_back(mk(0, 32'h30001, 32'hAB, 1'b1, base + 5));
      q0.push_back(mk(1, 32'h2, 32'h0, 1'b0, base + 6));
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("io_stall_mem_wr", {31'h0, mem_wr0}, 32'h0);
         chk("io_stall_mem_a", mem_a0, 32'h30000);
      end
      tick();
      io_full = 1'b0;
      tick(); tick();
      rv0[1] = 1'b0;
      tick(); tick();

      // Flushed word read on ch0 with a byte write pending on ch1
      rw0 = 2'b10; ra0 = {32'h40, 32'h110}; rs0 = {2'd0, 2'd2}; rwd0 = {32'h5A, 32'h0};
      rv0 = 2'b11; base = cyc;
      q0.push_back(mk(0, 32'h40, 32'h5A, 1'b1, base + 4));
      q0.push_back(mk(1, 32'h2, 32'h0, 1'b0, base + 5));
      tick(); tick();
      fl0 = 2'b01; rv0[0] = 1'b0;
      tick();
      fl0 = 2'b00;
      chk("flush_idle", {31'h0, busy0}, 32'h0);
      chk("flush_rdata_kept", rdata0, 32'h00000033);
      tick();
      chk("flush_next_grant", {29'h0, gid0}, 32'h1);
      tick();
      rv0[1] = 1'b0;
      tick(); tick();

      // Word write with rdy_in low for 3 cycles after the second byte
      rw0[0] = 1'b1; ra0[31:0] = 32'h200; rs0[1:0] = 2'd2; rwd0[31:0] = 32'hDDCCBBAA;
      rv0[0] = 1'b1; base = cyc;
      q0.push_back(mk(0, 32'h200, 32'hAA, 1'b1, base + 1));
      q0.push_back(mk(0, 32'h201, 32'hBB, 1'b1, base + 2));
      q0.push_back(mk(0, 32'h202, 32'hCC, 1'b1, base + 6));
      q0.push_back(mk(0, 32'h203, 32'hDD, 1'b1, base + 7));
      q0.push_back(mk(1, 32'h1, 32'h0, 1'b0, base + 8));
      tick(); tick(); tick();
      rdy = 1'b0;
      tick();
      chk("pause_mem_wr", {31'h0, mem_wr0}, 32'h0);
      chk("pause_mem_a", mem_a0, 32'h202);
      tick(); tick();
      rdy = 1'b1;
      tick(); tick();
      rv0[0] = 1'b0;
      tick(); tick();

      // Reset in the middle of a word read on ch1
      rw0[1] = 1'b0; ra0[63:32] = 32'h100; rs0[3:2] = 2'd2; rv0[1] = 1'b1;
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      chk("arst_mem_a", mem_a0, 32'h0);
      chk("arst_busy", {31'h0, busy0}, 32'h0);
      chk("arst_rdata", rdata0, 32'h0);
      chk("arst_grant", {29'h0, gid0}, 32'h0);
      chk("arst_done", {30'h0, done0}, 32'h0);
      rv0 = 2'b00;
      tick(); tick();
      rst = 1'b0;
      repeat (8) tick();

      // Round-robin: both channels requesting byte writes continuously
      rw1 = 2'b11; ra1 = {32'h20, 32'h10}; rs1 = 4'h0; rwd1 = {32'h02, 32'h01};
      rv1 = 2'b11; base = cyc;
      for (int k = 0; k < 2; k++) begin
         q1.push_back(mk(0, 32'h10, 32'h01, 1'b1, base + 1 + 4*k));
         q1.push_back(mk(1, 32'h1, 32'h0, 1'b0, base + 2 + 4*k));
         q1.push_back(mk(0, 32'h20, 32'h02, 1'b1, base + 3 + 4*k));
         q1.push_back(mk(1, 32'h2, 32'h0, 1'b0, base + 4 + 4*k));
      end
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c % 2 == 1) chk("rr_alt_grant", {29'h0, gid1}, (c % 4 == 1) ? 32'h0 : 32'h1);
         if (c == 8) rv1 = 2'b00;
      end
      tick(); tick(); tick();

      // Round-robin: ch1 joins while ch0 is eligible again; ch1 must win
      rv1 = 2'b01; base = cyc;
      q1.push_back(mk(0, 32'h10, 32'h01, 1'b1, base + 1));
      q1.push_back(mk(1, 32'h1, 32'h0, 1'b0, base + 2));
      q1.push_back(mk(0, 32'h20, 32'h02, 1'b1, base + 4));
      q1.push_back(mk(1, 32'h2, 32'h0, 1'b0, base + 5));
      q1.push_back(mk(0, 32'h10, 32'h01, 1'b1, base + 6));
      q1.push_back(mk(1, 32'h1, 32'h0, 1'b0, base + 7));
      q1.push_back(mk(0, 32'h20, 32'h02, 1'b1, base + 8));
      q1.push_back(mk(1, 32'h2, 32'h0, 1'b0, base + 9));
      for (int c = 1; c <= 9; c++) begin
         tick();
         if (c == 3) rv1 = 2'b11;
         if (c == 4) chk("rr_contend_grant", {29'h0, gid1}, 32'h1);
         if (c == 9) rv1 = 2'b00;
      end
      tick(); tick(); tick();

      chk("q0_drained", 32'(q0.size()), 32'h0);
      chk("q1_drained", 32'(q1.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
